// File: rtl/mul_seq_ctrl.sv
// Sequencer for a 32x32 multiply built from two passes through a registered
// 16x16 three-partial-product cell; returns the low or high product word.
module mul_seq_ctrl #(
   parameter int CELL_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [31:0] cell_src1,
   output logic [31:0] cell_src2,
   output logic        cell_en,
   input  logic [31:0] cell_p1,
   input  logic [31:0] cell_p2,
   input  logic [31:0] cell_p3
);

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULXSS = 2'b10;
   localparam logic [1:0] OP_MULXSU = 2'b11;
   localparam logic [1:0] CNT_INIT  = 2'(CELL_LATENCY - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE1,
      S_WAIT1,
      S_ISSUE2,
      S_WAIT2,
      S_CORR,
      S_DONE
   } state_t;

   state_t      r_state;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [1:0]  r_op;
   logic [1:0]  r_cnt;
   logic [63:0] r_lo;
   logic [31:0] r_hi;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_result;
   logic [31:0] r_cell_src1;
   logic [31:0] r_cell_src2;
   logic        r_cell_en;

   logic [32:0] w_mid;
   logic [63:0] w_lo;
   logic [31:0] w_hi;
   logic [31:0] w_corr_a;
   logic [31:0] w_corr_b;
   logic [31:0] w_corr;

   // Cross terms are summed at full 33-bit width before shifting into place.
   assign w_mid = {1'b0, cell_p2} + {1'b0, cell_p3};
   assign w_lo  = {32'h0, cell_p1} + {15'h0, w_mid, 16'h0};
   // A_hi*B_hi only contributes to the upper word, so add it there directly.
   assign w_hi  = r_lo[63:32] + cell_p1;

   assign w_corr_a = r_a[31] ? r_b : 32'h0;
   assign w_corr_b = r_b[31] ? r_a : 32'h0;

   always_comb begin
      w_corr = r_hi;
      case (r_op)
         OP_MULXSS: w_corr = r_hi - w_corr_a - w_corr_b;
         OP_MULXSU: w_corr = r_hi - w_corr_a;
         default:   w_corr = r_hi;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_a         <= 32'h0;
         r_b         <= 32'h0;
         r_op        <= 2'b00;
         r_cnt       <= 2'd0;
         r_lo        <= 64'h0;
         r_hi        <= 32'h0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_result    <= 32'h0;
         r_cell_src1 <= 32'h0;
         r_cell_src2 <= 32'h0;
         r_cell_en   <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_cell_en <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a         <= src1;
                  r_b         <= src2;
                  r_op        <= op;
                  r_cell_src1 <= src1;
                  r_cell_src2 <= src2;
                  r_cell_en   <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= S_ISSUE1;
               end
            end
            S_ISSUE1: begin
               r_cnt   <= CNT_INIT;
               r_state <= S_WAIT1;
            end
            S_WAIT1: begin
               if (r_cnt != 2'd0) begin
                  r_cnt <= r_cnt - 2'd1;
               end else begin
                  r_lo <= w_lo;
                  if (r_op == OP_MUL) begin
                     r_result <= w_lo[31:0];
                     r_done   <= 1'b1;
                     r_state  <= S_DONE;
                  end else begin
                     r_cell_src1 <= {16'h0, r_a[31:16]};
                     r_cell_src2 <= {16'h0, r_b[31:16]};
                     r_cell_en   <= 1'b1;
                     r_state     <= S_ISSUE2;
                  end
               end
            end
            S_ISSUE2: begin
               r_cnt   <= CNT_INIT;
               r_state <= S_WAIT2;
            end
            S_WAIT2: begin
               if (r_cnt != 2'd0) begin
                  r_cnt <= r_cnt - 2'd1;
               end else begin
                  r_hi    <= w_hi;
                  r_state <= S_CORR;
               end
            end
            S_CORR: begin
               r_result <= w_corr;
               r_done   <= 1'b1;
               r_state  <= S_DONE;
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign result    = r_result;
   assign cell_src1 = r_cell_src1;
   assign cell_src2 = r_cell_src2;
   assign cell_en   = r_cell_en;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: two instances (cell latency 1 and 3), each driving a
// behavioural pipelined cell, checked against plain 64-bit multiplication.
module tb_mul_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       reset_v;
   logic [1:0]       start_v;
   logic [1:0]       busy_v;
   logic [1:0]       done_v;
   logic [1:0]       cell_en_v;
   logic [1:0][1:0]  op_v;
   logic [1:0][31:0] src1_v;
   logic [1:0][31:0] src2_v;
   logic [1:0][31:0] result_v;
   logic [1:0][31:0] csrc1_v;
   logic [1:0][31:0] csrc2_v;

   int n_vec = 0;
   int n_err = 0;

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int LAT = (gi == 0) ? 1 : 3;
      logic [31:0] s1 [LAT];
      logic [31:0] s2 [LAT];
      logic [31:0] s3 [LAT];
      logic [31:0] p1_w;
      logic [31:0] p2_w;
      logic [31:0] p3_w;

      // Cell model: inputs sampled on an enabled edge, junk otherwise.
      always @(posedge clk) begin
         if (cell_en_v[gi]) begin
            s1[0] <= 32'(csrc1_v[gi][15:0])  * 32'(csrc2_v[gi][15:0]);
            s2[0] <= 32'(csrc1_v[gi][15:0])  * 32'(csrc2_v[gi][31:16]);
            s3[0] <= 32'(csrc1_v[gi][31:16]) * 32'(csrc2_v[gi][15:0]);
         end else begin
            s1[0] <= $urandom;
            s2[0] <= $urandom;
            s3[0] <= $urandom;
         end
         for (int i = 1; i < LAT; i++) begin
            s1[i] <= s1[i-1];
            s2[i] <= s2[i-1];
            s3[i] <= s3[i-1];
         end
      end
      assign p1_w = s1[LAT-1];
      assign p2_w = s2[LAT-1];
      assign p3_w = s3[LAT-1];

      mul_seq_ctrl #(.CELL_LATENCY(LAT)) u_dut (
         .clk       (clk),
         .reset     (reset_v[gi]),
         .start     (start_v[gi]),
         .op        (op_v[gi]),
         .src1      (src1_v[gi]),
         .src2      (src2_v[gi]),
         .busy      (busy_v[gi]),
         .done      (done_v[gi]),
         .result    (result_v[gi]),
         .cell_src1 (csrc1_v[gi]),
         .cell_src2 (csrc2_v[gi]),
         .cell_en   (cell_en_v[gi]),
         .cell_p1   (p1_w),
         .cell_p2   (p2_w),
         .cell_p3   (p3_w)
      );
   end

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea;
      logic [63:0] eb;
      logic [63:0] p;
      ea = (op[1]) ? {{32{a[31]}}, a} : {32'h0, a};
      eb = (op == 2'b10) ? {{32{b[31]}}, b} : {32'h0, b};
      p  = ea * eb;
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called at the falling edge right after the accepting rising edge.
   task automatic wait_done(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      int          n;
      int          en_cnt;
      int          lat;
      bit          got;
      bit          held;
      logic [31:0] exp;
      logic [31:0] prev;
      n = 1; en_cnt = 0; got = 1'b0; held = 1'b1;
      exp  = ref_mul(op, a, b);
      lat  = (op == 2'b00) ? 2 + lat_of(k) : 4 + 2 * lat_of(k);
      prev = result_v[k];
      chk_eq("busy_after_accept", 32'(busy_v[k]), 32'd1);
      while (!got) begin
         if (cell_en_v[k]) begin
            en_cnt++;
            if (en_cnt == 1) begin
               chk_eq("cell_src1_pass1", csrc1_v[k], a);
               chk_eq("cell_src2_pass1", csrc2_v[k], b);
            end else begin
               chk_eq("cell_src1_pass2", csrc1_v[k], {16'h0, a[31:16]});
               chk_eq("cell_src2_pass2", csrc2_v[k], {16'h0, b[31:16]});
            end
         end
         if (done_v[k]) begin
            got = 1'b1;
            chk_eq("latency", 32'(n), 32'(lat));
            chk_eq("result", result_v[k], exp);
            chk_eq("cell_en_pulses", 32'(en_cnt), (op == 2'b00) ? 32'd1 : 32'd2);
            chk_eq("busy_in_done", 32'(busy_v[k]), 32'd1);
         end else begin
            if (result_v[k] !== prev) held = 1'b0;
            if (n >= 60) begin
               n_vec++;
               n_err++;
               $display("FAIL done_timeout: inst %0d no done after %0d cycles, expected %0d", k, n, lat);
               got = 1'b1;
            end else begin
               @(negedge clk);
               n++;
            end
         end
      end
      chk_eq("result_held", 32'(held), 32'd1);
      $display("inst %0d op %0d a=%h b=%h -> result=%h expected=%h cycles=%0d", k, op, a, b, result_v[k], exp, n);
      @(negedge clk);
      chk_eq("done_cleared", 32'(done_v[k]), 32'd0);
      chk_eq("busy_cleared", 32'(busy_v[k]), 32'd0);
      chk_eq("result_after", result_v[k], exp);
   endtask

   task automatic run_op(input int k, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      start_v[k] = 1'b1;
      op_v[k]    = op;
      src1_v[k]  = a;
      src2_v[k]  = b;
      @(negedge clk);
      start_v[k] = 1'b0;
      op_v[k]    = 2'($urandom);
      src1_v[k]  = $urandom;
      src2_v[k]  = $urandom;
      wait_done(k, op, a, b);
   endtask

   // start stays high across a whole operation; second request enters after done.
   task automatic run_hold(input int k, input logic [1:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                           input logic [1:0] op2, input logic [31:0] a2, input logic [31:0] b2);
      start_v[k] = 1'b1;
      op_v[k]    = op1;
      src1_v[k]  = a1;
      src2_v[k]  = b1;
      @(negedge clk);
      op_v[k]    = op2;
      src1_v[k]  = a2;
      src2_v[k]  = b2;
      wait_done(k, op1, a1, b1);
      @(negedge clk);
      start_v[k] = 1'b0;
      src1_v[k]  = $urandom;
      src2_v[k]  = $urandom;
      wait_done(k, op2, a2, b2);
   endtask

   task automatic check_reset_state(input int k);
      chk_eq("rst_busy", 32'(busy_v[k]), 32'd0);
      chk_eq("rst_done", 32'(done_v[k]), 32'd0);
      chk_eq("rst_result", result_v[k], 32'd0);
      chk_eq("rst_cell_en", 32'(cell_en_v[k]), 32'd0);
      chk_eq("rst_cell_src1", csrc1_v[k], 32'd0);
      chk_eq("rst_cell_src2", csrc2_v[k], 32'd0);
   endtask

   task automatic run_reset_mid(input int k);
      bit seen;
      seen = 1'b0;
      start_v[k] = 1'b1;
      op_v[k]    = 2'b01;
      src1_v[k]  = $urandom;
      src2_v[k]  = $urandom;
      @(negedge clk);
      start_v[k] = 1'b0;
      repeat (2 + lat_of(k)) @(negedge clk);
      reset_v[k] = 1'b1;
      @(negedge clk);
      check_reset_state(k);
      reset_v[k] = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done_v[k] || busy_v[k]) seen = 1'b1;
      end
      chk_eq("no_activity_after_reset", 32'(seen), 32'd0);
      $display("inst %0d reset in WAIT2 -> request discarded", k);
      run_op(k, 2'b00, 32'd7, 32'd6);
   endtask

   function automatic logic [31:0] rand_operand();
      logic [31:0] corner [5];
      corner[0] = 32'h0000_0000;
      corner[1] = 32'h0000_0001;
      corner[2] = 32'hFFFF_FFFF;
      corner[3] = 32'h8000_0000;
      corner[4] = 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   initial begin
      reset_v  = 2'b11;
      start_v  = 2'b00;
      op_v     = '0;
      src1_v   = '0;
      src2_v   = '0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) check_reset_state(k);
      reset_v = 2'b00;
      @(negedge clk);

      for (int k = 0; k < 2; k++) begin
         run_op(k, 2'b00, 32'h0001_0003, 32'h0002_0005);
         run_op(k, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
         run_op(k, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
         run_op(k, 2'b10, 32'h8000_0000, 32'h0000_0002);
         run_op(k, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
         run_op(k, 2'b11, 32'h0000_0002, 32'h8000_0000);
         run_hold(k, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'h8000_0000, 32'h0000_0002);
         run_reset_mid(k);
         for (int i = 0; i < 25; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 2'($urandom_range(0, 3));
            ra  = rand_operand();
            rb  = rand_operand();
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            run_op(k, rop, ra, rb);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
